rr_select_arbiter: RTL and testbench

- Four-channel round-robin arbiter that drives the 2-bit select of the downstream 4:1 bit multiplexer.
- Decides which of four requesters owns the shared mux output.
- Holds that grant until the owner releases it, drops its request, or exceeds a hold limit.
- Outputs the encoded select plus a one-hot grant and a grant-valid flag.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 30 +++
 rtl/rr_select_arbiter.sv | 74 +++++++
 tb/tb_rr_select_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin mux-select arbiter.
// FSM encoding, requester count, select and hold-counter widths.
package arb_pkg;

  localparam int N     = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N-1:0] onehot(
    input logic [SEL_W-1:0] sel
  );
    return N'(1) << sel;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request
// starting at ptr and wrapping modulo N.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int i = 0; i < N; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_select_arbiter.sv
// Four-channel round-robin arbiter driving a 4:1 mux select.
// Grant is held until done, request drop or hold-limit expiry.
module rr_select_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [SEL_W-1:0] s,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid
);

  localparam bit HOLD_EN = (MAX_HOLD != 0);
  localparam int HOLD_LI = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_LI);

  state_e           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] win;
  logic             any;
  logic             hold_hit;
  logic             rel;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (win),
    .any    (any)
  );

  assign hold_hit = HOLD_EN && (cnt == HOLD_LAST);
  assign rel      = done || !req[s] || hold_hit;

  // s is kept across IDLE so the mux output stays stable
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s         <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      cnt       <= '0;
      ptr       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            state     <= GRANT;
            s         <= win;
            gnt       <= onehot(win);
            gnt_valid <= 1'b1;
            cnt       <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= s + 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Random and directed stimulus for rr_select_arbiter, checked
// against a channel-level reference model of the arbitration rules.
module tb_rr_select_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic [1:0] s;
  logic [3:0] gnt;
  logic       gnt_valid;

  int n_vec = 0;
  int n_err = 0;

  // reference model: owner index or -1, last owner, next priority,
  // number of grant cycles the owner has had so far
  int m_owner = -1;
  int m_last  = 0;
  int m_prio  = 0;
  int m_held  = 0;

  rr_select_arbiter #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .s         (s),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_step(
    input logic       r,
    input logic [3:0] q,
    input logic       d
  );
    int c;
    if (r) begin
      m_owner = -1;
      m_last  = 0;
      m_prio  = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        c = (m_prio + k) % 4;
        if (m_owner < 0 && q[c]) begin
          m_owner = c;
          m_last  = c;
          m_held  = 1;
        end
      end
    end else if (d || !q[m_owner] || (MH != 0 && m_held == MH)) begin
      m_prio  = (m_owner + 1) % 4;
      m_owner = -1;
    end else if (m_held < 256) begin
      m_held++;
    end
  endtask

  task automatic step(
    input logic       r,
    input logic [3:0] q,
    input logic       d
  );
    logic [3:0] eg;
    rst  = r;
    req  = q;
    done = d;
    @(posedge clk);
    model_step(r, q, d);
    #1;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    check("gnt", {4'b0, gnt}, {4'b0, eg});
    check("s", {6'b0, s}, 8'(m_last));
    check("gnt_valid", {7'b0, gnt_valid}, {7'b0, m_owner >= 0});
  endtask

  task automatic rr_done_step(input logic [3:0] q);
    step(1'b0, q, (m_owner >= 0 && m_held == 2));
  endtask

  logic [3:0] rq;

  initial begin
    // reset with all requests high
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    // round-robin with done on the second grant cycle
    for (int i = 0; i < 16; i++) rr_done_step(4'b1111);

    // single request, done pulse later
    step(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 4'b0100, (i == 5));

    // hold-limit timeouts between ch0 and ch3
    step(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 24; i++) step(1'b0, 4'b1001, 1'b0);

    // request drop mid-grant
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0010, 1'b0);
    step(1'b0, 4'b0110, 1'b0);
    step(1'b0, 4'b0110, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0100, 1'b0);

    // reset mid-grant
    step(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 1'b0);
    step(1'b1, 4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 1'b0);

    // done ignored while idle
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b1000, 1'b1);

    // random traffic
    rq = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0), rq,
           ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
